// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with WB bypass, load-use bubble insertion
//            and a saturating bubble counter.
// Revision : 1.0
// ============================================================================
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_wa,
    input  logic [31:0]       id_rd1,
    input  logic [31:0]       id_rd2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              wb_we,
    input  logic [4:0]        wb_wa,
    input  logic [31:0]       wb_wd,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_wa,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              lu_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        bypass_a;
    logic        bypass_b;

    // Same-cycle WB write wins over the stale regfile read; r0 is never bypassed.
    assign bypass_a = wb_we && (wb_wa != 5'd0) && (wb_wa == id_rs);
    assign bypass_b = wb_we && (wb_wa != 5'd0) && (wb_wa == id_rt);
    assign a_in     = bypass_a ? wb_wd : id_rd1;
    assign b_in     = bypass_b ? wb_wd : id_rd2;

    assign lu_stall = ex_valid && ex_memread && (ex_wa != 5'd0) && id_valid &&
                      ((ex_wa == id_rs) || (ex_wa == id_rt));

    // Control bits of a bubble are cleared; data fields simply hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_wa       <= '0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= '0;
        end else if (flush || (!stall && lu_stall)) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
        end else if (!stall) begin
            ex_valid    <= id_valid;
            ex_regwrite <= id_regwrite & id_valid;
            ex_memread  <= id_memread & id_valid;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_wa       <= id_wa;
            ex_a        <= a_in;
            ex_b        <= b_in;
            ex_imm      <= id_imm;
            ex_ctrl     <= id_ctrl;
        end
    end

    // Only load-use bubbles are counted, never flushes or holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (!flush && !stall && lu_stall && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed vector bench for id_ex_stage (default and 4-bit counter).
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_wa = '0;
    logic [31:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic [7:0]  id_ctrl = '0;
    logic        id_regwrite = 1'b0, id_memread = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_wa = '0;
    logic [31:0] wb_wd = '0;

    logic        ex_valid, ex_regwrite, ex_memread, lu_stall;
    logic [4:0]  ex_rs, ex_rt, ex_wa;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [7:0]  ex_ctrl;
    logic [15:0] bubble_cnt;

    logic        s_valid, s_regwrite, s_memread, s_lu;
    logic [4:0]  s_rs, s_rt, s_wa;
    logic [31:0] s_a, s_b, s_imm;
    logic [7:0]  s_ctrl;
    logic [3:0]  s_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.CTRL_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_wa(id_wa), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wa(ex_wa),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .lu_stall(lu_stall),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.CTRL_W(8), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_wa(id_wa), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .ex_valid(s_valid), .ex_rs(s_rs), .ex_rt(s_rt), .ex_wa(s_wa),
        .ex_a(s_a), .ex_b(s_b), .ex_imm(s_imm), .ex_ctrl(s_ctrl),
        .ex_regwrite(s_regwrite), .ex_memread(s_memread), .lu_stall(s_lu),
        .bubble_cnt(s_cnt)
    );

    typedef struct {
        logic        st, fl, v;
        logic [4:0]  rs, rt, wa;
        logic [31:0] rd1, rd2, imm;
        logic [7:0]  ctrl;
        logic        rw, mr, we;
        logic [4:0]  wwa;
        logic [31:0] wwd;
        logic        e_lu, e_v, e_rw, e_mr, cd;
        logic [4:0]  e_rs, e_wa;
        logic [31:0] e_a, e_b, e_imm;
        logic [7:0]  e_ctrl;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [17];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] wa, input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_wa = wa;
        id_regwrite = rw; id_memread = mr;
    endtask

    initial begin
        //            st fl v rs rt wa  rd1      rd2      imm      ctrl   rw mr we wwa wwd
        //            | lu ev erw emr cd ers ewa ea       eb       eimm     ectrl  ecnt
        vecs[0]  = '{0,0,1, 5, 6, 7, 'h11,    'h22,    'h100,   'h5A,  1,0,1, 5,'hABCD,
                     0,1,1,0,1, 5, 7, 'hABCD,  'h22,    'h100,   'h5A,  0};
        vecs[1]  = '{0,0,1, 0, 6, 8, 'h0,     'h33,    'h200,   'h11,  1,0,1, 0,'hFFFF,
                     0,1,1,0,1, 0, 8, 'h0,     'h33,    'h200,   'h11,  0};
        vecs[2]  = '{0,0,1, 1, 9, 3, 'h44,    'h55,    'h300,   'h22,  1,1,1, 9,'h99,
                     0,1,1,1,1, 1, 3, 'h44,    'h99,    'h300,   'h22,  0};
        vecs[3]  = '{0,0,1, 3, 4,10, 'h66,    'h77,    'h400,   'h33,  1,0,0, 3,'hDEAD,
                     1,0,0,0,0, 0, 0, 'h0,     'h0,     'h0,     'h0,   1};
        vecs[4]  = '{0,0,1, 3, 4,10, 'h66,    'h77,    'h400,   'h33,  1,0,0, 3,'hDEAD,
                     0,1,1,0,1, 3,10, 'h66,    'h77,    'h400,   'h33,  1};
        vecs[5]  = '{0,0,0, 2, 0,12, 'h123,   'h456,   'h500,   'h44,  1,1,0, 0,'h0,
                     0,0,0,0,1, 2,12, 'h123,   'h456,   'h500,   'h44,  1};
        vecs[6]  = '{0,0,1, 1, 2, 4, 'h1234,  'h5678,  'h600,   'h55,  1,1,0, 0,'h0,
                     0,1,1,1,1, 1, 4, 'h1234,  'h5678,  'h600,   'h55,  1};
        vecs[7]  = '{0,1,1, 7, 4,11, 'h1,     'h2,     'h700,   'h66,  1,0,0, 0,'h0,
                     1,0,0,0,0, 0, 0, 'h0,     'h0,     'h0,     'h0,   1};
        vecs[8]  = '{0,0,1, 1, 2, 5, 'h1234,  'hBEEF,  'h800,   'h77,  1,0,0, 0,'h0,
                     0,1,1,0,1, 1, 5, 'h1234,  'hBEEF,  'h800,   'h77,  1};
        vecs[9]  = '{1,0,1, 5, 5,20, 'hAAAA,  'hBBBB,  'h900,   'h88,  0,1,1, 5,'hCCCC,
                     0,1,1,0,1, 1, 5, 'h1234,  'hBEEF,  'h800,   'h77,  1};
        vecs[10] = '{1,0,0, 6, 7,21, 'h1,     'h2,     'h3,     'h99,  1,1,0, 0,'h0,
                     0,1,1,0,1, 1, 5, 'h1234,  'hBEEF,  'h800,   'h77,  1};
        vecs[11] = '{1,0,1, 2, 1,22, 'h5,     'h6,     'h7,     'hAB,  0,0,1, 2,'h77,
                     0,1,1,0,1, 1, 5, 'h1234,  'hBEEF,  'h800,   'h77,  1};
        vecs[12] = '{0,0,1, 1, 2, 6, 'hAA,    'hBB,    'hA00,   'hC1,  1,1,0, 0,'h0,
                     0,1,1,1,1, 1, 6, 'hAA,    'hBB,    'hA00,   'hC1,  1};
        vecs[13] = '{1,0,1, 8, 6,13, 'hCC,    'hDD,    'hB00,   'hC2,  1,0,0, 0,'h0,
                     1,1,1,1,1, 1, 6, 'hAA,    'hBB,    'hA00,   'hC1,  1};
        vecs[14] = '{0,0,1, 8, 6,13, 'hCC,    'hDD,    'hB00,   'hC2,  1,0,0, 0,'h0,
                     1,0,0,0,0, 0, 0, 'h0,     'h0,     'h0,     'h0,   2};
        vecs[15] = '{0,0,1, 1, 2, 9, 'hEE,    'hFF,    'hC00,   'hC3,  1,0,0, 0,'h0,
                     0,1,1,0,1, 1, 9, 'hEE,    'hFF,    'hC00,   'hC3,  2};
        vecs[16] = '{1,1,1, 3, 4,14, 'h1,     'h2,     'h3,     'hC4,  1,1,0, 0,'h0,
                     0,0,0,0,0, 0, 0, 'h0,     'h0,     'h0,     'h0,   2};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            stall = vecs[i].st; flush = vecs[i].fl;
            drive_id(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].wa, vecs[i].rw, vecs[i].mr);
            id_rd1 = vecs[i].rd1; id_rd2 = vecs[i].rd2;
            id_imm = vecs[i].imm; id_ctrl = vecs[i].ctrl;
            wb_we = vecs[i].we; wb_wa = vecs[i].wwa; wb_wd = vecs[i].wwd;
            #1;
            chk($sformatf("v%0d lu_stall", i), {31'd0, lu_stall}, {31'd0, vecs[i].e_lu});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_v});
            chk($sformatf("v%0d ex_regwrite", i), {31'd0, ex_regwrite}, {31'd0, vecs[i].e_rw});
            chk($sformatf("v%0d ex_memread", i), {31'd0, ex_memread}, {31'd0, vecs[i].e_mr});
            chk($sformatf("v%0d bubble_cnt", i), {16'd0, bubble_cnt}, {16'd0, vecs[i].e_cnt});
            if (vecs[i].cd) begin
                chk($sformatf("v%0d ex_rs", i), {27'd0, ex_rs}, {27'd0, vecs[i].e_rs});
                chk($sformatf("v%0d ex_wa", i), {27'd0, ex_wa}, {27'd0, vecs[i].e_wa});
                chk($sformatf("v%0d ex_a", i), ex_a, vecs[i].e_a);
                chk($sformatf("v%0d ex_b", i), ex_b, vecs[i].e_b);
                chk($sformatf("v%0d ex_imm", i), ex_imm, vecs[i].e_imm);
                chk($sformatf("v%0d ex_ctrl", i), {24'd0, ex_ctrl}, {24'd0, vecs[i].e_ctrl});
            end
        end

        // Asynchronous reset mid-hazard, observed with no clock edge in between.
        @(negedge clk);
        stall = 1'b0; flush = 1'b0; wb_we = 1'b0;
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        id_rd1 = 32'h5555; id_rd2 = 32'h6666; id_imm = 32'h7777; id_ctrl = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        drive_id(1'b1, 5'd3, 5'd0, 5'd9, 1'b1, 1'b0);
        #1;
        chk("pre_reset lu_stall", {31'd0, lu_stall}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("async ex_memread", {31'd0, ex_memread}, 32'd0);
        chk("async ex_regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("async ex_wa", {27'd0, ex_wa}, 32'd0);
        chk("async ex_rs", {27'd0, ex_rs}, 32'd0);
        chk("async ex_a", ex_a, 32'd0);
        chk("async ex_imm", ex_imm, 32'd0);
        chk("async ex_ctrl", {24'd0, ex_ctrl}, 32'd0);
        chk("async bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("async lu_stall", {31'd0, lu_stall}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // Twenty load-use bubbles: 4-bit counter saturates, 16-bit keeps counting.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
            @(negedge clk);
            drive_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            if (i == 14) chk("small cnt at 15 bubbles", {28'd0, s_cnt}, 32'd15);
        end
        chk("small cnt saturated", {28'd0, s_cnt}, 32'd15);
        chk("wide cnt 20", {16'd0, bubble_cnt}, 32'd20);
        @(negedge clk);
        chk("after bubble lu_stall", {31'd0, lu_stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("after bubble ex_rs", {27'd0, ex_rs}, 32'd3);
        chk("after bubble ex_valid", {31'd0, ex_valid}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
